// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer: entry storage layout and
// the packet presented to the commit stage.
package reorder_buffer_pkg;

  localparam int PREG_W    = 6;
  localparam int ROB_DEPTH = 16;
  localparam int ROB_TAG_W = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic              valid;
    logic              completed;
    logic              mispredict;
    logic [31:0]       pc;
    logic              writes_rd;
    logic [4:0]        rd_arch;
    logic [PREG_W-1:0] rd_phys;
    logic [PREG_W-1:0] old_phys;
    logic [31:0]       rd_val;
  } rob_entry_t;

  typedef struct packed {
    logic [31:0]       pc;
    logic              writes_rd;
    logic [4:0]        rd_arch;
    logic [PREG_W-1:0] rd_phys;
    logic [PREG_W-1:0] old_phys;
    logic [31:0]       rd_val;
  } rob_commit_t;

  // Commit payload of an entry, forced to zero when nothing is retiring.
  function automatic rob_commit_t make_commit(input rob_entry_t e, input logic en);
    rob_commit_t c;
    c = '0;
    if (en) begin
      c.pc        = e.pc;
      c.writes_rd = e.writes_rd;
      c.rd_arch   = e.rd_arch;
      c.rd_phys   = e.rd_phys;
      c.old_phys  = e.old_phys;
      c.rd_val    = e.rd_val;
    end
    return c;
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: dispatch allocates at tail, writeback completes by
// tag, head retires in program order; a retiring mispredict flushes everything.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              alloc_valid_i,
  output logic              alloc_ready_o,
  input  logic [31:0]       alloc_pc_i,
  input  logic              alloc_writes_rd_i,
  input  logic [4:0]        alloc_rd_arch_i,
  input  logic [PREG_W-1:0] alloc_rd_phys_i,
  input  logic [PREG_W-1:0] alloc_old_phys_i,
  output logic [TAG_W-1:0]  alloc_tag_o,
  input  logic              complete_valid_i,
  input  logic [TAG_W-1:0]  complete_tag_i,
  input  logic [31:0]       complete_rd_val_i,
  input  logic              complete_mispredict_i,
  output logic              commit_valid_o,
  input  logic              commit_ready_i,
  output logic [TAG_W-1:0]  commit_tag_o,
  output logic [31:0]       commit_pc_o,
  output logic              commit_writes_rd_o,
  output logic [4:0]        commit_rd_arch_o,
  output logic [PREG_W-1:0] commit_rd_phys_o,
  output logic [PREG_W-1:0] commit_old_phys_o,
  output logic [31:0]       commit_rd_val_o,
  output logic              recover_o,
  output logic [TAG_W:0]    count_o,
  output logic              empty_o
);

  localparam logic [TAG_W:0]   FULL_CNT = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W+1)'(1);
  localparam logic [TAG_W-1:0] PTR_ONE  = TAG_W'(1);

  rob_entry_t       r_entries [DEPTH];
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;

  rob_entry_t  w_head_entry;
  rob_commit_t w_commit;
  logic        w_commit_valid;
  logic        w_commit_fire;
  logic        w_recover;
  logic        w_alloc_ready;
  logic        w_alloc_fire;
  logic        w_complete_hit;

  assign w_head_entry   = r_entries[r_head];
  assign w_commit_valid = w_head_entry.valid && w_head_entry.completed;
  assign w_commit_fire  = w_commit_valid && commit_ready_i;
  assign w_recover      = w_commit_fire && w_head_entry.mispredict;
  // No same-cycle bypass when full: the slot freed by a commit is usable next cycle.
  assign w_alloc_ready  = (r_count != FULL_CNT) && !w_recover;
  assign w_alloc_fire   = alloc_valid_i && w_alloc_ready;
  assign w_complete_hit = complete_valid_i && r_entries[complete_tag_i].valid;
  assign w_commit       = make_commit(w_head_entry, w_commit_valid);

  always_ff @(posedge clk_i) begin
    if (reset_i || w_recover) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i].valid      <= 1'b0;
        r_entries[i].completed  <= 1'b0;
        r_entries[i].mispredict <= 1'b0;
      end
    end else begin
      if (w_complete_hit) begin
        r_entries[complete_tag_i].completed  <= 1'b1;
        r_entries[complete_tag_i].mispredict <= complete_mispredict_i;
        r_entries[complete_tag_i].rd_val     <= complete_rd_val_i;
      end
      if (w_commit_fire) begin
        r_entries[r_head].valid <= 1'b0;
        r_head                  <= r_head + PTR_ONE;
      end
      if (w_alloc_fire) begin
        r_entries[r_tail] <= '{valid:      1'b1,
                               completed:  1'b0,
                               mispredict: 1'b0,
                               pc:         alloc_pc_i,
                               writes_rd:  alloc_writes_rd_i,
                               rd_arch:    alloc_rd_arch_i,
                               rd_phys:    alloc_rd_phys_i,
                               old_phys:   alloc_old_phys_i,
                               rd_val:     32'd0};
        r_tail            <= r_tail + PTR_ONE;
      end
      unique case ({w_alloc_fire, w_commit_fire})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign alloc_ready_o      = w_alloc_ready;
  assign alloc_tag_o        = r_tail;
  assign commit_valid_o     = w_commit_valid;
  assign commit_tag_o       = w_commit_valid ? r_head : '0;
  assign commit_pc_o        = w_commit.pc;
  assign commit_writes_rd_o = w_commit.writes_rd;
  assign commit_rd_arch_o   = w_commit.rd_arch;
  assign commit_rd_phys_o   = w_commit.rd_phys;
  assign commit_old_phys_o  = w_commit.old_phys;
  assign commit_rd_val_o    = w_commit.rd_val;
  assign recover_o          = w_recover;
  assign count_o            = r_count;
  assign empty_o            = (r_count == '0);

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios then random traffic, all checked
// every cycle against a queue-based model of in-order retirement.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int D = 16;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              alloc_valid_i;
  logic              alloc_ready_o;
  logic [31:0]       alloc_pc_i;
  logic              alloc_writes_rd_i;
  logic [4:0]        alloc_rd_arch_i;
  logic [PREG_W-1:0] alloc_rd_phys_i;
  logic [PREG_W-1:0] alloc_old_phys_i;
  logic [3:0]        alloc_tag_o;
  logic              complete_valid_i;
  logic [3:0]        complete_tag_i;
  logic [31:0]       complete_rd_val_i;
  logic              complete_mispredict_i;
  logic              commit_valid_o;
  logic              commit_ready_i;
  logic [3:0]        commit_tag_o;
  logic [31:0]       commit_pc_o;
  logic              commit_writes_rd_o;
  logic [4:0]        commit_rd_arch_o;
  logic [PREG_W-1:0] commit_rd_phys_o;
  logic [PREG_W-1:0] commit_old_phys_o;
  logic [31:0]       commit_rd_val_o;
  logic              recover_o;
  logic [4:0]        count_o;
  logic              empty_o;

  reorder_buffer #(.DEPTH(D)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_pc_i(alloc_pc_i), .alloc_writes_rd_i(alloc_writes_rd_i),
    .alloc_rd_arch_i(alloc_rd_arch_i), .alloc_rd_phys_i(alloc_rd_phys_i),
    .alloc_old_phys_i(alloc_old_phys_i), .alloc_tag_o(alloc_tag_o),
    .complete_valid_i(complete_valid_i), .complete_tag_i(complete_tag_i),
    .complete_rd_val_i(complete_rd_val_i), .complete_mispredict_i(complete_mispredict_i),
    .commit_valid_o(commit_valid_o), .commit_ready_i(commit_ready_i),
    .commit_tag_o(commit_tag_o), .commit_pc_o(commit_pc_o),
    .commit_writes_rd_o(commit_writes_rd_o), .commit_rd_arch_o(commit_rd_arch_o),
    .commit_rd_phys_o(commit_rd_phys_o), .commit_old_phys_o(commit_old_phys_o),
    .commit_rd_val_o(commit_rd_val_o), .recover_o(recover_o),
    .count_o(count_o), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          tag;
    logic [31:0] pc;
    logic        wr;
    logic [4:0]  arch;
    logic [5:0]  phys;
    logic [5:0]  old;
    logic        done;
    logic        misp;
    logic [31:0] val;
  } ment_t;

  ment_t       mq[$];
  int          mtail;
  logic [31:0] committed[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_rec_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, clock, then advance the model.
  task automatic cyc();
    ment_t h;
    logic  cv, fire_c, rec, rdy, fire_a;
    int    n;
    #1;
    h = '{default: 0};
    n = mq.size();
    if (n > 0) h = mq[0];
    cv     = (n > 0) && h.done;
    fire_c = cv && commit_ready_i;
    rec    = fire_c && h.misp;
    rdy    = (n < D) && !rec;
    fire_a = alloc_valid_i && rdy;
    chk("alloc_ready", alloc_ready_o, rdy);
    chk("alloc_tag", alloc_tag_o, mtail);
    chk("count", count_o, n);
    chk("empty", empty_o, n == 0);
    chk("commit_valid", commit_valid_o, cv);
    chk("recover", recover_o, rec);
    chk("commit_tag", commit_tag_o, cv ? h.tag : 0);
    chk("commit_pc", commit_pc_o, cv ? h.pc : 0);
    chk("commit_wr", commit_writes_rd_o, cv ? h.wr : 1'b0);
    chk("commit_arch", commit_rd_arch_o, cv ? h.arch : 5'd0);
    chk("commit_phys", commit_rd_phys_o, cv ? h.phys : 6'd0);
    chk("commit_old", commit_old_phys_o, cv ? h.old : 6'd0);
    chk("commit_val", commit_rd_val_o, cv ? h.val : 0);
    if (recover_o === 1'b1) n_rec_seen++;
    @(posedge clk_i);
    if (reset_i) begin
      mq.delete();
      mtail = 0;
    end else if (rec) begin
      committed.push_back(h.pc);
      mq.delete();
      mtail = 0;
    end else begin
      if (complete_valid_i)
        foreach (mq[i])
          if (mq[i].tag == int'(complete_tag_i)) begin
            mq[i].done = 1'b1;
            mq[i].misp = complete_mispredict_i;
            mq[i].val  = complete_rd_val_i;
          end
      if (fire_c) begin
        committed.push_back(h.pc);
        void'(mq.pop_front());
      end
      if (fire_a) begin
        mq.push_back('{tag: mtail, pc: alloc_pc_i, wr: alloc_writes_rd_i,
                       arch: alloc_rd_arch_i, phys: alloc_rd_phys_i,
                       old: alloc_old_phys_i, done: 1'b0, misp: 1'b0, val: 0});
        mtail = (mtail + 1) % D;
      end
    end
    #1;
  endtask

  task automatic set_alloc(input logic v, input logic [31:0] pc);
    alloc_valid_i     = v;
    alloc_pc_i        = pc;
    alloc_writes_rd_i = 1'($urandom);
    alloc_rd_arch_i   = 5'($urandom);
    alloc_rd_phys_i   = 6'($urandom);
    alloc_old_phys_i  = 6'($urandom);
  endtask

  task automatic alloc_one(input logic [31:0] pc);
    set_alloc(1'b1, pc);
    cyc();
    alloc_valid_i = 1'b0;
  endtask

  task automatic complete(input int tag, input logic misp);
    complete_valid_i      = 1'b1;
    complete_tag_i        = 4'(tag);
    complete_mispredict_i = misp;
    complete_rd_val_i     = $urandom;
    cyc();
    complete_valid_i      = 1'b0;
    complete_mispredict_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
  endtask

  initial begin
    logic [31:0] held_pc, held_val;
    reset_i = 1'b1;
    set_alloc(1'b0, 32'd0);
    complete_valid_i      = 1'b0;
    complete_tag_i        = '0;
    complete_rd_val_i     = '0;
    complete_mispredict_i = 1'b0;
    commit_ready_i        = 1'b1;
    mtail = 0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    chk("rst_count", count_o, 0);
    chk("rst_ready", alloc_ready_o, 1);
    chk("rst_empty", empty_o, 1);
    chk("rst_cv", commit_valid_o, 0);

    // In-order retirement despite reverse completion order.
    alloc_one(32'h0); alloc_one(32'h4); alloc_one(32'h8);
    complete(2, 1'b0);
    complete(1, 1'b0);
    chk("s1_cv_before", commit_valid_o, 0);
    complete(0, 1'b0);
    chk("s1_cv_after", commit_valid_o, 1);
    committed.delete();
    repeat (4) cyc();
    chk("s1_ncommit", committed.size(), 3);
    if (committed.size() == 3) begin
      chk("s1_pc0", committed[0], 32'h0);
      chk("s1_pc1", committed[1], 32'h4);
      chk("s1_pc2", committed[2], 32'h8);
    end

    // Fill to capacity, then free one slot and see the tail wrap.
    do_reset();
    for (int i = 0; i < D; i++) alloc_one(32'(i * 4));
    chk("full_ready", alloc_ready_o, 0);
    chk("full_count", count_o, 16);
    set_alloc(1'b1, 32'h100);
    cyc();
    alloc_valid_i = 1'b0;
    complete(0, 1'b0);
    cyc();
    chk("wrap_ready", alloc_ready_o, 1);
    chk("wrap_tag", alloc_tag_o, 0);

    // Back-pressure keeps the head packet stable.
    commit_ready_i = 1'b0;
    complete(1, 1'b0);
    held_pc  = commit_pc_o;
    held_val = commit_rd_val_o;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("hold_cv", commit_valid_o, 1);
      chk("hold_pc", commit_pc_o, held_pc);
      chk("hold_val", commit_rd_val_o, held_val);
    end
    commit_ready_i = 1'b1;
    cyc();
    chk("hold_release_count", count_o, 14);
    chk("hold_release_cv", commit_valid_o, 0);

    // Mispredict retires and flushes.
    do_reset();
    for (int i = 0; i < 4; i++) alloc_one(32'(32'h200 + i * 4));
    n_rec_seen = 0;
    complete(1, 1'b1);
    complete(0, 1'b0);
    complete(2, 1'b0);
    complete(3, 1'b0);
    cyc();
    chk("misp_recover_once", n_rec_seen, 1);
    chk("misp_count", count_o, 0);
    chk("misp_empty", empty_o, 1);
    chk("misp_tag", alloc_tag_o, 0);

    // Simultaneous alloc+commit, then completion to an unallocated tag.
    do_reset();
    for (int i = 0; i < 5; i++) alloc_one(32'(32'h300 + i * 4));
    complete(0, 1'b0);
    set_alloc(1'b1, 32'h400);
    cyc();
    alloc_valid_i = 1'b0;
    chk("same_cycle_count", count_o, 5);
    complete(9, 1'b0);
    cyc();
    chk("tag9_cv", commit_valid_o, 0);
    chk("tag9_count", count_o, 5);

    // Reset with live entries.
    do_reset();
    for (int i = 0; i < 7; i++) alloc_one(32'(32'h500 + i * 4));
    do_reset();
    chk("midrst_count", count_o, 0);
    chk("midrst_cv", commit_valid_o, 0);
    chk("midrst_tag", alloc_tag_o, 0);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      set_alloc(($urandom % 10) < 7, $urandom);
      complete_valid_i      = ($urandom % 3) != 0;
      if (mq.size() > 0 && ($urandom % 4) != 0)
        complete_tag_i = 4'(mq[$urandom % mq.size()].tag);
      else
        complete_tag_i = 4'($urandom);
      complete_rd_val_i     = $urandom;
      complete_mispredict_i = ($urandom % 16) == 0;
      commit_ready_i        = ($urandom % 4) != 0;
      reset_i               = ($urandom % 100) == 0;
      cyc();
    end
    reset_i          = 1'b0;
    alloc_valid_i    = 1'b0;
    complete_valid_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
